// File: rtl/seg7_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_driver
// Description : Latches a 4-digit BCD value on a load strobe and drives four
//               active-low 7-segment displays (HEX0..HEX3) with power-on
//               lamp test, leading-zero blanking, dash for invalid codes,
//               per-digit decimal points and PWM dimming.
//               Optional blink feature enabled by defining SEG_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_driver #(
  parameter int LAMP_CYCLES = 50_000_000,
  parameter int PWM_BITS    = 3,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [3:0]          i_units,
  input  logic [3:0]          i_tens,
  input  logic [3:0]          i_hundreds,
  input  logic [3:0]          i_thousands,
  input  logic [3:0]          i_dp,
  input  logic                i_lzb,
  input  logic [PWM_BITS-1:0] i_bright,
`ifdef SEG_BLINK_EN
  input  logic                i_blink,
`endif
  output logic                o_busy,
  output logic [7:0]          o_hex0,
  output logic [7:0]          o_hex1,
  output logic [7:0]          o_hex2,
  output logic [7:0]          o_hex3
);

  localparam int LAMP_W = $clog2(LAMP_CYCLES + 1);
  localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_CYCLES - 1);

  // Parameter sanity check at elaboration time.
  if (LAMP_CYCLES < 1 || PWM_BITS < 1 || BLINK_HALF < 1) begin : g_bad_params
    $error("seg7_display_driver: LAMP_CYCLES, PWM_BITS and BLINK_HALF must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_LAMP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [LAMP_W-1:0]     lamp_cnt_q, lamp_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [3:0][3:0]       digit_q, digit_d;   // [3]=thousands .. [0]=units
  logic [3:0]            dp_q, dp_d;
  logic [3:0][7:0]       hex_q, hex_d;
  logic                  busy_q, busy_d;
  logic                  blink_off;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; codes above 9 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Blink half-period counter; the phase flips each time the counter wraps.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_off = i_blink & blink_phase_q;
`else
  assign blink_off = 1'b0;
`endif

  // Lamp-test sequencing: hold LAMP for LAMP_CYCLES cycles, then RUN forever.
  always_comb begin
    state_d    = state_q;
    lamp_cnt_d = lamp_cnt_q;
    case (state_q)
      ST_LAMP: begin
        if (lamp_cnt_q == LAMP_LAST) begin
          state_d = ST_RUN;
        end else begin
          lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_LAMP;
    endcase
  end

  // Digit capture, PWM counter and the registered segment image.
  always_comb begin
    logic [3:0] blank;
    logic       pwm_on;
    logic [6:0] seg;

    digit_d   = i_load ? {i_thousands, i_hundreds, i_tens, i_units} : digit_q;
    dp_d      = i_load ? i_dp : dp_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    busy_d    = (state_q == ST_LAMP);
    pwm_on    = (pwm_cnt_q <= i_bright);
    hex_d     = '1;
    seg       = '1;

    // Blanking ripples down from the most significant digit; units always shown.
    blank[3] = i_lzb && (digit_q[3] == 4'd0);
    blank[2] = blank[3] && (digit_q[2] == 4'd0);
    blank[1] = blank[2] && (digit_q[1] == 4'd0);
    blank[0] = 1'b0;

    for (int i = 0; i < 4; i++) begin
      seg      = blank[i] ? 7'h7F : seg_decode(digit_q[i]);
      hex_d[i] = {~dp_q[i], seg};
      if (!pwm_on || blink_off) begin
        hex_d[i] = 8'hFF;
      end
      if (state_q == ST_LAMP) begin
        hex_d[i] = 8'h00;
      end
    end
  end

  // State, counters, latched digits and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_LAMP;
      lamp_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      digit_q    <= '0;
      dp_q       <= '0;
      hex_q      <= {4{8'hFF}};
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lamp_cnt_q <= lamp_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      digit_q    <= digit_d;
      dp_q       <= dp_d;
      hex_q      <= hex_d;
      busy_q     <= busy_d;
    end
  end

  assign o_busy = busy_q;
  assign o_hex0 = hex_q[0];
  assign o_hex1 = hex_q[1];
  assign o_hex2 = hex_q[2];
  assign o_hex3 = hex_q[3];

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display_driver
// Description : Scoreboard bench for seg7_display_driver. The driver pushes the
//               expected post-edge outputs; a monitor pops and compares them.
//               Blink checks are included when SEG_BLINK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] units = 4'd0, tens = 4'd0, hund = 4'd0, thou = 4'd0, dp = 4'd0;
  logic       lzb = 1'b0;
  logic [1:0] bright = 2'd3;
  logic       blink = 1'b0;
  logic       busy;
  logic [7:0] hex0, hex1, hex2, hex3;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    string      name;
    logic [7:0] h3, h2, h1, h0;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  seg7_display_driver #(
    .LAMP_CYCLES(4),
    .PWM_BITS   (2),
    .BLINK_HALF (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (load),
    .i_units    (units),
    .i_tens     (tens),
    .i_hundreds (hund),
    .i_thousands(thou),
    .i_dp       (dp),
    .i_lzb      (lzb),
    .i_bright   (bright),
`ifdef SEG_BLINK_EN
    .i_blink    (blink),
`endif
    .o_busy     (busy),
    .o_hex0     (hex0),
    .o_hex1     (hex1),
    .o_hex2     (hex2),
    .o_hex3     (hex3)
  );

  always #5 clk = ~clk;

  // Push the expectation for the coming edge, then advance one cycle.
  task automatic step(input string nm, input logic [7:0] e3, e2, e1, e0, input logic eb);
    exp_t e;
    e.name = nm; e.h3 = e3; e.h2 = e2; e.h1 = e1; e.h0 = e0; e.busy = eb;
    exp_q.push_back(e);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic set_digits(input logic [3:0] t, h, te, u, input logic [3:0] d);
    load = 1'b1; thou = t; hund = h; tens = te; units = u; dp = d;
  endtask

  // PWM window: counter value used at the coming edge is edge_n mod 4.
  function automatic logic [7:0] pw(input logic [7:0] v);
    return ((edge_n % 4) <= int'(bright)) ? v : 8'hFF;
  endfunction

`ifdef SEG_BLINK_EN
  function automatic logic [7:0] bl(input logic [7:0] v);
    return (((edge_n / 3) % 2) == 1) ? 8'hFF : v;
  endfunction
`endif

  // Monitor: compare each registered output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (hex3 !== e.h3 || hex2 !== e.h2 || hex1 !== e.h1 || hex0 !== e.h0 || busy !== e.busy) begin
          errors++;
          $display("FAIL %s: got hex3..0=%h %h %h %h busy=%b, expected %h %h %h %h busy=%b",
                   e.name, hex3, hex2, hex1, hex0, busy, e.h3, e.h2, e.h1, e.h0, e.busy);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset and lamp test
    rst = 1'b1;
    step("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    step("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    rst = 1'b0; edge_n = 0;
    for (int i = 0; i < 4; i++) step("lamp", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    step("run_zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);
    step("run_zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);

    // Plain load 1234 (output updates one edge after capture)
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    step("load_edge", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);
    load = 1'b0;
    step("show_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);

    // Leading-zero blanking
    lzb = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
    step("lzb_live_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
    set_digits(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000);
    step("lzb_0007", 8'hFF, 8'hFF, 8'hFF, 8'hF8, 1'b0);
    load = 1'b0;
    step("lzb_0050", 8'hFF, 8'hFF, 8'h92, 8'hC0, 1'b0);

    // Invalid code and decimal points
    lzb = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'hA, 4'b0000);
    step("nolzb_0050", 8'hC0, 8'hC0, 8'h92, 8'hC0, 1'b0);
    set_digits(4'd0, 4'd0, 4'd0, 4'd8, 4'b0001);
    step("dash", 8'hC0, 8'hC0, 8'hC0, 8'hBF, 1'b0);
    load = 1'b0; lzb = 1'b1;
    step("dp_on_8_lzb", 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
    step("load_dp3", 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    load = 1'b0;
    step("dp_blanked", 8'h7F, 8'hFF, 8'hFF, 8'hC0, 1'b0);
    set_digits(4'hB, 4'd0, 4'd0, 4'd1, 4'b0000);
    step("load_b001", 8'h7F, 8'hFF, 8'hFF, 8'hC0, 1'b0);
    load = 1'b0;
    step("invalid_nonzero", 8'hBF, 8'hC0, 8'hC0, 8'hF9, 1'b0);

    // PWM dimming
    lzb = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    step("pre_pwm", 8'hBF, 8'hC0, 8'hC0, 8'hF9, 1'b0);
    load = 1'b0;
    bright = 2'd1;
    for (int i = 0; i < 8; i++)
      step("pwm_b1", pw(8'hF9), pw(8'hA4), pw(8'hB0), pw(8'h99), 1'b0);
    bright = 2'd0;
    for (int i = 0; i < 8; i++)
      step("pwm_b0", pw(8'hF9), pw(8'hA4), pw(8'hB0), pw(8'h99), 1'b0);
    bright = 2'd2;
    for (int i = 0; i < 4; i++)
      step("pwm_b2", pw(8'hF9), pw(8'hA4), pw(8'hB0), pw(8'h99), 1'b0);
    bright = 2'd3;
    step("pwm_b3", 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);

`ifdef SEG_BLINK_EN
    blink = 1'b1;
    for (int i = 0; i < 12; i++)
      step("blink", bl(8'hF9), bl(8'hA4), bl(8'hB0), bl(8'h99), 1'b0);
    blink = 1'b0;
    for (int i = 0; i < 4; i++)
      step("blink_off", 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
`endif

    // Reset mid-RUN wins over a simultaneous load
    rst = 1'b1;
    set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
    step("rst_and_load", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    rst = 1'b0; load = 1'b0; dp = 4'b0000; edge_n = 0;
    for (int i = 0; i < 4; i++) step("lamp_restart", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    step("run_after_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
